// File: rtl/plot_port_arbiter.sv
// Round-robin owner of the VGA plot port: each granted request becomes one
// BOX_W x BOX_H filled rectangle. A done pulse is sent back to the requester that was served.
module plot_port_arbiter #(
    parameter int BOX_W = 4,
    parameter int BOX_H = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       req0,
    input  logic [7:0] iX0,
    input  logic [6:0] iY0,
    input  logic [2:0] iColour0,
    input  logic       req1,
    input  logic [7:0] iX1,
    input  logic [6:0] iY1,
    input  logic [2:0] iColour1,
    output logic       grant0,
    output logic       grant1,
    output logic       done0,
    output logic       done1,
    output logic [7:0] oX,
    output logic [6:0] oY,
    output logic [2:0] oColour,
    output logic       oPlot,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PLOT, DONE} state_t;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } burst_t;

    localparam logic [3:0] CX_MAX = 4'(BOX_W - 1);
    localparam logic [3:0] CY_MAX = 4'(BOX_H - 1);

    state_t     state_q, state_d;
    burst_t     burst_q, burst_d;
    logic [3:0] cx_q, cx_d;
    logic [3:0] cy_q, cy_d;
    logic       gid_q, gid_d;
    logic       last_q, last_d;
    logic       sel;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            burst_q <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            gid_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            burst_q <= burst_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
        end
    end

    // Under contention the requester not served last time wins.
    always_comb begin
        sel = (req0 && req1) ? ~last_q : req1;
    end

    always_comb begin
        state_d = state_q;
        burst_d = burst_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        gid_d   = gid_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    gid_d   = sel;
                    burst_d = sel ? '{x: iX1, y: iY1, c: iColour1}
                                  : '{x: iX0, y: iY0, c: iColour0};
                    cx_d    = '0;
                    cy_d    = '0;
                    state_d = PLOT;
                end
            end
            PLOT: begin
                if (cx_q == CX_MAX) begin
                    cx_d = '0;
                    if (cy_q == CY_MAX) state_d = DONE;
                    else                cy_d    = cy_q + 4'd1;
                end else begin
                    cx_d = cx_q + 4'd1;
                end
            end
            DONE: begin
                last_d  = gid_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs come only from registers; the pixel address wraps at the port width.
    always_comb begin
        oPlot   = (state_q == PLOT);
        busy    = (state_q != IDLE);
        grant0  = busy && !gid_q;
        grant1  = busy && gid_q;
        done0   = (state_q == DONE) && !gid_q;
        done1   = (state_q == DONE) && gid_q;
        oX      = '0;
        oY      = '0;
        oColour = '0;
        if (oPlot) begin
            oX      = burst_q.x + {4'd0, cx_q};
            oY      = burst_q.y + {3'd0, cy_q};
            oColour = burst_q.c;
        end
    end

endmodule
